// File: rtl/tl_xing_pkg.sv
// Shared TileLink definitions for the bus-crossing A-channel arbiter:
// opcode enums and burst-length helpers.
package tl_xing_pkg;

  typedef enum logic [2:0] {
    A_PUT_FULL      = 3'd0,
    A_PUT_PARTIAL   = 3'd1,
    A_ARITH         = 3'd2,
    A_LOGIC         = 3'd3,
    A_GET           = 3'd4,
    A_HINT          = 3'd5,
    A_ACQUIRE_BLOCK = 3'd6,
    A_ACQUIRE_PERM  = 3'd7
  } a_opcode_e;

  typedef enum logic [2:0] {
    D_ACCESS_ACK      = 3'd0,
    D_ACCESS_ACK_DATA = 3'd1,
    D_HINT_ACK        = 3'd2,
    D_GRANT           = 3'd4,
    D_GRANT_DATA      = 3'd5,
    D_RELEASE_ACK     = 3'd6
  } d_opcode_e;

  function automatic logic has_data(input logic [2:0] opcode);
    return a_opcode_e'(opcode) inside {A_PUT_FULL, A_PUT_PARTIAL, A_ARITH, A_LOGIC};
  endfunction

  function automatic int unsigned num_beats(input logic [2:0] opcode,
                                            input int unsigned size,
                                            input int unsigned log2_bb);
    if (has_data(opcode) && size > log2_bb)
      return 32'd1 << (size - log2_bb);
    return 32'd1;
  endfunction

  // Wide enough to hold beats-1 for the largest encodable size.
  function automatic int cnt_w(input int size_w, input int log2_bb);
    int w;
    w = (2 ** size_w) - 1 - log2_bb;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping to 0. Index falls back to ptr when nothing is valid.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] index
);

  logic found;
  int   j_idx;

  always_comb begin
    grant = '0;
    index = ptr;
    found = 1'b0;
    j_idx = 0;
    for (int i = 0; i < N; i++) begin
      j_idx = int'(ptr) + i;
      if (j_idx >= N) j_idx = j_idx - N;
      if (!found && valid[j_idx]) begin
        found        = 1'b1;
        grant[j_idx] = 1'b1;
        index        = IW'(j_idx);
      end
    end
  end

endmodule

// File: rtl/tl_xing_a_arbiter.sv
// Shares the coupler's TileLink bus-crossing input between NUM_REQ requesters:
// round-robin A arbitration with burst locking, D routed back by source prefix.
module tl_xing_a_arbiter
  import tl_xing_pkg::*;
#(
  parameter int  NUM_REQ = 2,
  parameter int  SRC_W   = 4,
  parameter int  ADDR_W  = 32,
  parameter int  DATA_W  = 64,
  parameter int  SIZE_W  = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_a_valid,
  output logic [NUM_REQ-1:0]           req_a_ready,
  input  logic [NUM_REQ*3-1:0]         req_a_bits_opcode,
  input  logic [NUM_REQ*3-1:0]         req_a_bits_param,
  input  logic [NUM_REQ*SIZE_W-1:0]    req_a_bits_size,
  input  logic [NUM_REQ*SRC_W-1:0]     req_a_bits_source,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_a_bits_address,
  input  logic [NUM_REQ*DATA_W/8-1:0]  req_a_bits_mask,
  input  logic [NUM_REQ*DATA_W-1:0]    req_a_bits_data,
  input  logic [NUM_REQ-1:0]           req_a_bits_corrupt,
  output logic                         out_a_valid,
  input  logic                         out_a_ready,
  output logic [2:0]                   out_a_bits_opcode,
  output logic [2:0]                   out_a_bits_param,
  output logic [SIZE_W-1:0]            out_a_bits_size,
  output logic [SRC_W+IDX_W-1:0]       out_a_bits_source,
  output logic [ADDR_W-1:0]            out_a_bits_address,
  output logic [DATA_W/8-1:0]          out_a_bits_mask,
  output logic [DATA_W-1:0]            out_a_bits_data,
  output logic                         out_a_bits_corrupt,
  input  logic                         out_d_valid,
  output logic                         out_d_ready,
  input  logic [2:0]                   out_d_bits_opcode,
  input  logic [1:0]                   out_d_bits_param,
  input  logic [SIZE_W-1:0]            out_d_bits_size,
  input  logic [SRC_W+IDX_W-1:0]       out_d_bits_source,
  input  logic [3:0]                   out_d_bits_sink,
  input  logic                         out_d_bits_denied,
  input  logic [DATA_W-1:0]            out_d_bits_data,
  input  logic                         out_d_bits_corrupt,
  output logic [NUM_REQ-1:0]           req_d_valid,
  input  logic [NUM_REQ-1:0]           req_d_ready,
  output logic [2:0]                   req_d_bits_opcode,
  output logic [1:0]                   req_d_bits_param,
  output logic [SIZE_W-1:0]            req_d_bits_size,
  output logic [SRC_W-1:0]             req_d_bits_source,
  output logic [3:0]                   req_d_bits_sink,
  output logic                         req_d_bits_denied,
  output logic [DATA_W-1:0]            req_d_bits_data,
  output logic                         req_d_bits_corrupt,
  output logic                         err_bad_source
);

  localparam int LOG2_BB = $clog2(DATA_W / 8);
  localparam int CNT_W   = cnt_w(SIZE_W, LOG2_BB);
  localparam int MASK_W  = DATA_W / 8;

  logic [IDX_W-1:0]   ptr_reg;
  logic [IDX_W-1:0]   lock_idx_reg;
  logic               locked_reg;
  logic [CNT_W-1:0]   beats_left_reg;
  logic               err_reg;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic [NUM_REQ-1:0] grant_onehot;
  logic               a_fire;
  logic               first_beat;
  logic               last_beat;
  logic [CNT_W-1:0]   burst_len_m1;
  logic [IDX_W-1:0]   ptr_inc;

  rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .valid (req_a_valid),
    .ptr   (ptr_reg),
    .grant (pick_onehot),
    .index (pick_idx)
  );

  assign grant_idx    = locked_reg ? lock_idx_reg : pick_idx;
  assign grant_onehot = locked_reg ? (NUM_REQ'(1) << lock_idx_reg) : pick_onehot;

  assign out_a_valid  = reset & req_a_valid[grant_idx];
  assign req_a_ready  = reset ? (grant_onehot & {NUM_REQ{out_a_ready}}) : '0;

  assign out_a_bits_opcode  = req_a_bits_opcode[int'(grant_idx)*3 +: 3];
  assign out_a_bits_param   = req_a_bits_param[int'(grant_idx)*3 +: 3];
  assign out_a_bits_size    = req_a_bits_size[int'(grant_idx)*SIZE_W +: SIZE_W];
  assign out_a_bits_source  = {grant_idx, req_a_bits_source[int'(grant_idx)*SRC_W +: SRC_W]};
  assign out_a_bits_address = req_a_bits_address[int'(grant_idx)*ADDR_W +: ADDR_W];
  assign out_a_bits_mask    = req_a_bits_mask[int'(grant_idx)*MASK_W +: MASK_W];
  assign out_a_bits_data    = req_a_bits_data[int'(grant_idx)*DATA_W +: DATA_W];
  assign out_a_bits_corrupt = req_a_bits_corrupt[grant_idx];

  // beats_left_reg == 0 means no burst has started, so the next fire is a first beat.
  assign a_fire       = out_a_valid & out_a_ready;
  assign burst_len_m1 = CNT_W'(num_beats(out_a_bits_opcode, int'(out_a_bits_size), LOG2_BB) - 1);
  assign first_beat   = (beats_left_reg == '0);
  assign last_beat    = first_beat ? (burst_len_m1 == '0) : (beats_left_reg == CNT_W'(1));
  assign ptr_inc      = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  logic [IDX_W-1:0]   d_idx;
  logic [NUM_REQ-1:0] d_hit;
  logic               d_ok;

  assign d_idx = out_d_bits_source[SRC_W +: IDX_W];
  assign d_ok  = |d_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_d_route
      assign d_hit[gi]       = (d_idx == IDX_W'(gi));
      assign req_d_valid[gi] = reset & out_d_valid & d_hit[gi];
    end
  endgenerate

  // Unroutable prefixes are sunk so the coupler never stalls on them.
  assign out_d_ready = reset & (d_ok ? |(req_d_ready & d_hit) : 1'b1);

  assign req_d_bits_opcode  = out_d_bits_opcode;
  assign req_d_bits_param   = out_d_bits_param;
  assign req_d_bits_size    = out_d_bits_size;
  assign req_d_bits_source  = out_d_bits_source[SRC_W-1:0];
  assign req_d_bits_sink    = out_d_bits_sink;
  assign req_d_bits_denied  = out_d_bits_denied;
  assign req_d_bits_data    = out_d_bits_data;
  assign req_d_bits_corrupt = out_d_bits_corrupt;
  assign err_bad_source     = err_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr_reg        <= '0;
      lock_idx_reg   <= '0;
      locked_reg     <= 1'b0;
      beats_left_reg <= '0;
      err_reg        <= 1'b0;
    end else begin
      if (a_fire) begin
        if (last_beat) begin
          locked_reg     <= 1'b0;
          beats_left_reg <= '0;
          ptr_reg        <= ptr_inc;
        end else begin
          locked_reg     <= 1'b1;
          lock_idx_reg   <= grant_idx;
          beats_left_reg <= first_beat ? burst_len_m1 : beats_left_reg - 1'b1;
        end
      end else if (out_a_valid) begin
        locked_reg   <= 1'b1;
        lock_idx_reg <= grant_idx;
      end
      if (out_d_valid && !d_ok)
        err_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tl_xing_a_arbiter.sv
// Bench for tl_xing_a_arbiter: directed scenarios plus a randomized run
// checked against a message-level arbitration model.
module tb_tl_xing_a_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // NUM_REQ=2 instance
  logic [1:0]   a_valid = '0, a_ready_o;
  logic [5:0]   a_op, a_param = '0;
  logic [7:0]   a_size, a_src;
  logic [63:0]  a_addr;
  logic [15:0]  a_mask = '1;
  logic [127:0] a_data;
  logic [1:0]   a_corrupt = '0;
  logic         o_valid, o_ready = 1'b0;
  logic [2:0]   o_op, o_param;
  logic [3:0]   o_size;
  logic [4:0]   o_src;
  logic [31:0]  o_addr;
  logic [7:0]   o_mask;
  logic [63:0]  o_data;
  logic         o_corrupt;
  logic         d_valid = 1'b0, d_ready_o;
  logic [2:0]   d_op = '0;
  logic [1:0]   d_param = '0;
  logic [3:0]   d_size = '0, d_sink = '0;
  logic [4:0]   d_src = '0;
  logic         d_denied = 1'b0, d_corrupt = 1'b0;
  logic [63:0]  d_data = '0;
  logic [1:0]   rd_valid, rd_ready = '0;
  logic [2:0]   rd_op;
  logic [1:0]   rd_param;
  logic [3:0]   rd_size, rd_src, rd_sink;
  logic         rd_denied, rd_corrupt, err;
  logic [63:0]  rd_data;

  logic [2:0]  op_q[2];
  logic [3:0]  sz_q[2], src_q[2];
  logic [31:0] adr_q[2];
  logic [63:0] dat_q[2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      a_op[i*3 +: 3]    = op_q[i];
      a_size[i*4 +: 4]  = sz_q[i];
      a_src[i*4 +: 4]   = src_q[i];
      a_addr[i*32 +: 32] = adr_q[i];
      a_data[i*64 +: 64] = dat_q[i];
    end
  end

  tl_xing_a_arbiter #(.NUM_REQ(2), .SRC_W(4), .ADDR_W(32), .DATA_W(64), .SIZE_W(4)) dut (
    .clock(clk), .reset(rst_n),
    .req_a_valid(a_valid), .req_a_ready(a_ready_o),
    .req_a_bits_opcode(a_op), .req_a_bits_param(a_param), .req_a_bits_size(a_size),
    .req_a_bits_source(a_src), .req_a_bits_address(a_addr), .req_a_bits_mask(a_mask),
    .req_a_bits_data(a_data), .req_a_bits_corrupt(a_corrupt),
    .out_a_valid(o_valid), .out_a_ready(o_ready),
    .out_a_bits_opcode(o_op), .out_a_bits_param(o_param), .out_a_bits_size(o_size),
    .out_a_bits_source(o_src), .out_a_bits_address(o_addr), .out_a_bits_mask(o_mask),
    .out_a_bits_data(o_data), .out_a_bits_corrupt(o_corrupt),
    .out_d_valid(d_valid), .out_d_ready(d_ready_o),
    .out_d_bits_opcode(d_op), .out_d_bits_param(d_param), .out_d_bits_size(d_size),
    .out_d_bits_source(d_src), .out_d_bits_sink(d_sink), .out_d_bits_denied(d_denied),
    .out_d_bits_data(d_data), .out_d_bits_corrupt(d_corrupt),
    .req_d_valid(rd_valid), .req_d_ready(rd_ready),
    .req_d_bits_opcode(rd_op), .req_d_bits_param(rd_param), .req_d_bits_size(rd_size),
    .req_d_bits_source(rd_src), .req_d_bits_sink(rd_sink), .req_d_bits_denied(rd_denied),
    .req_d_bits_data(rd_data), .req_d_bits_corrupt(rd_corrupt),
    .err_bad_source(err)
  );

  // NUM_REQ=3 instance, exercised on the D path only
  logic [2:0]   t3_a_valid = '0, t3_a_ready_o, t3_a_corrupt = '0;
  logic [8:0]   t3_a_op = '0, t3_a_param = '0;
  logic [11:0]  t3_a_size = '0, t3_a_src = '0;
  logic [95:0]  t3_a_addr = '0;
  logic [23:0]  t3_a_mask = '0;
  logic [191:0] t3_a_data = '0;
  logic         t3_o_valid, t3_o_corrupt, t3_d_ready_o;
  logic [2:0]   t3_o_op, t3_o_param;
  logic [3:0]   t3_o_size;
  logic [5:0]   t3_o_src;
  logic [31:0]  t3_o_addr;
  logic [7:0]   t3_o_mask;
  logic [63:0]  t3_o_data, t3_rd_data;
  logic         t3_d_valid = 1'b0;
  logic [5:0]   t3_d_src = '0;
  logic [2:0]   t3_rd_valid, t3_rd_ready = '0, t3_rd_op;
  logic [1:0]   t3_rd_param;
  logic [3:0]   t3_rd_size, t3_rd_src, t3_rd_sink;
  logic         t3_rd_denied, t3_rd_corrupt, t3_err;

  tl_xing_a_arbiter #(.NUM_REQ(3), .SRC_W(4), .ADDR_W(32), .DATA_W(64), .SIZE_W(4)) dut3 (
    .clock(clk), .reset(rst_n),
    .req_a_valid(t3_a_valid), .req_a_ready(t3_a_ready_o),
    .req_a_bits_opcode(t3_a_op), .req_a_bits_param(t3_a_param), .req_a_bits_size(t3_a_size),
    .req_a_bits_source(t3_a_src), .req_a_bits_address(t3_a_addr), .req_a_bits_mask(t3_a_mask),
    .req_a_bits_data(t3_a_data), .req_a_bits_corrupt(t3_a_corrupt),
    .out_a_valid(t3_o_valid), .out_a_ready(1'b1),
    .out_a_bits_opcode(t3_o_op), .out_a_bits_param(t3_o_param), .out_a_bits_size(t3_o_size),
    .out_a_bits_source(t3_o_src), .out_a_bits_address(t3_o_addr), .out_a_bits_mask(t3_o_mask),
    .out_a_bits_data(t3_o_data), .out_a_bits_corrupt(t3_o_corrupt),
    .out_d_valid(t3_d_valid), .out_d_ready(t3_d_ready_o),
    .out_d_bits_opcode(d_op), .out_d_bits_param(d_param), .out_d_bits_size(d_size),
    .out_d_bits_source(t3_d_src), .out_d_bits_sink(d_sink), .out_d_bits_denied(d_denied),
    .out_d_bits_data(d_data), .out_d_bits_corrupt(d_corrupt),
    .req_d_valid(t3_rd_valid), .req_d_ready(t3_rd_ready),
    .req_d_bits_opcode(t3_rd_op), .req_d_bits_param(t3_rd_param), .req_d_bits_size(t3_rd_size),
    .req_d_bits_source(t3_rd_src), .req_d_bits_sink(t3_rd_sink), .req_d_bits_denied(t3_rd_denied),
    .req_d_bits_data(t3_rd_data), .req_d_bits_corrupt(t3_rd_corrupt),
    .err_bad_source(t3_err)
  );

  // Reference model: current burst owner (-1 = none), beats still owed, rr pointer.
  int m_ptr, m_owner, m_rem;

  function automatic int beats_of(input logic [2:0] op, input logic [3:0] sz);
    if (op <= 3'd3 && sz > 4'd3) return 1 << (int'(sz) - 3);
    return 1;
  endfunction

  function automatic int m_grant();
    if (m_owner >= 0) return m_owner;
    for (int k = 0; k < 2; k++) begin
      int j = (m_ptr + k) % 2;
      if (a_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_ptr = 0; m_owner = -1; m_rem = 0;
  endtask

  task automatic m_step(input int g, input bit pres, input bit rdy);
    if (!pres) return;
    if (!rdy) begin m_owner = g; return; end
    if (m_rem == 0) m_rem = beats_of(op_q[g], sz_q[g]);
    m_rem--;
    if (m_rem == 0) begin m_owner = -1; m_ptr = (g + 1) % 2; end
    else m_owner = g;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = '0; d_valid = 1'b0; t3_d_valid = 1'b0; o_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    a_valid = 2'b11; op_q[0] = 3'd4; op_q[1] = 3'd4; o_ready = 1'b1;
    d_valid = 1'b1; d_src = 5'h01; rd_ready = 2'b11;
    #1 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_valid, a_ready_o, rd_valid, d_ready_o} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b required 000000", {o_valid, a_ready_o, rd_valid, d_ready_o});
    end
    n_vec++;
    if ({err, t3_err} !== 2'b00) begin
      n_err++;
      $display("FAIL reset_err: got %b required 00", {err, t3_err});
    end
    do_reset();
  endtask

  task automatic test_single_get();
    do_reset();
    a_valid = 2'b01; op_q[0] = 3'd4; sz_q[0] = 4'd3; src_q[0] = 4'hA; adr_q[0] = 32'h1234_5678;
    o_ready = 1'b1;
    #1;
    n_vec++;
    if ({o_valid, a_ready_o, o_src, o_addr} !== {1'b1, 2'b01, 5'h0A, 32'h1234_5678}) begin
      n_err++;
      $display("FAIL single_get: got v=%b rdy=%b src=%h addr=%h required 1 01 0a 12345678",
               o_valid, a_ready_o, o_src, o_addr);
    end
    tick();
    a_valid = 2'b11; op_q[1] = 3'd4; sz_q[1] = 4'd3;
    #1;
    n_vec++;
    if (o_src[4] !== 1'b1) begin
      n_err++;
      $display("FAIL single_get_ptr: got grant %b required 1", o_src[4]);
    end
    tick();
    a_valid = '0;
  endtask

  task automatic test_alternate();
    do_reset();
    a_valid = 2'b11; op_q[0] = 3'd4; op_q[1] = 3'd4; sz_q[0] = 4'd6; sz_q[1] = 4'd3;
    o_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      src_q[0] = 4'($urandom); src_q[1] = 4'($urandom);
      #1;
      n_vec++;
      if ({o_src, a_ready_o} !== {1'(k % 2), src_q[k % 2], 2'(1 << (k % 2))}) begin
        n_err++;
        $display("FAIL alternate[%0d]: got src=%h rdy=%b required src=%h rdy=%b", k, o_src, a_ready_o,
                 {1'(k % 2), src_q[k % 2]}, 2'(1 << (k % 2)));
      end
      tick();
    end
    a_valid = '0;
  endtask

  task automatic test_burst_lock();
    logic [5:0] pat;
    pat = 6'b101101;
    do_reset();
    a_valid = 2'b01; op_q[0] = 3'd4; sz_q[0] = 4'd3; o_ready = 1'b1;
    tick();
    a_valid = 2'b11; op_q[1] = 3'd0; sz_q[1] = 4'd5;
    for (int c = 0; c < 6; c++) begin
      o_ready = pat[c]; dat_q[1] = {$urandom, $urandom};
      #1;
      n_vec++;
      if ({o_valid, o_src[4], o_data} !== {1'b1, 1'b1, dat_q[1]}) begin
        n_err++;
        $display("FAIL burst_lock[%0d]: got v=%b grant=%b data=%h required 1 1 %h", c, o_valid,
                 o_src[4], o_data, dat_q[1]);
      end
      tick();
    end
    o_ready = 1'b1;
    #1;
    n_vec++;
    if (o_src[4] !== 1'b0) begin
      n_err++;
      $display("FAIL burst_release: got grant %b required 0", o_src[4]);
    end
    tick();
    a_valid = '0;
  endtask

  task automatic test_stall_hold();
    do_reset();
    a_valid = 2'b01; op_q[0] = 3'd4; op_q[1] = 3'd4; sz_q[0] = 4'd2; o_ready = 1'b1;
    tick();
    o_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) a_valid = 2'b11;
      #1;
      n_vec++;
      if ({o_valid, o_src[4], a_ready_o} !== {1'b1, 1'b0, 2'b00}) begin
        n_err++;
        $display("FAIL stall_hold[%0d]: got v=%b grant=%b rdy=%b required 1 0 00", c, o_valid, o_src[4], a_ready_o);
      end
      tick();
    end
    o_ready = 1'b1;
    #1;
    n_vec++;
    if ({o_src[4], a_ready_o} !== {1'b0, 2'b01}) begin
      n_err++;
      $display("FAIL stall_fire: got grant=%b rdy=%b required 0 01", o_src[4], a_ready_o);
    end
    tick();
    a_valid = 2'b10;
    #1;
    n_vec++;
    if (o_src[4] !== 1'b1) begin
      n_err++;
      $display("FAIL stall_next: got grant %b required 1", o_src[4]);
    end
    tick();
    a_valid = '0;
  endtask

  task automatic test_d_route();
    do_reset();
    d_valid = 1'b1; d_src = {1'b1, 4'h5}; d_data = {$urandom, $urandom}; rd_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rd_ready = 2'b11;
      #1;
      n_vec++;
      if ({rd_valid, d_ready_o, rd_src, rd_data} !== {2'b10, c == 2, 4'h5, d_data}) begin
        n_err++;
        $display("FAIL d_route_1[%0d]: got v=%b rdy=%b src=%h required 10 %b 5", c, rd_valid, d_ready_o,
                 rd_src, c == 2);
      end
      tick();
    end
    d_src = {1'b0, 4'h2}; rd_ready = 2'b10;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) rd_ready = 2'b01;
      #1;
      n_vec++;
      if ({rd_valid, d_ready_o, rd_src} !== {2'b01, c == 1, 4'h2}) begin
        n_err++;
        $display("FAIL d_route_0[%0d]: got v=%b rdy=%b src=%h required 01 %b 2", c, rd_valid, d_ready_o,
                 rd_src, c == 1);
      end
      tick();
    end
    d_valid = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    a_valid = 2'b01; op_q[0] = 3'd4; sz_q[0] = 4'd3; o_ready = 1'b1;
    tick();
    a_valid = 2'b10; op_q[1] = 3'd0; sz_q[1] = 4'd5;
    tick(); tick();
    d_valid = 1'b1; d_src = 5'h03; rd_ready = 2'b11;
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({o_valid, a_ready_o, rd_valid, d_ready_o} !== 6'b0) begin
      n_err++;
      $display("FAIL midburst_reset_outputs: got %b required 000000", {o_valid, a_ready_o, rd_valid, d_ready_o});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; d_valid = 1'b0; a_valid = 2'b11; o_ready = 1'b0;
    #1;
    n_vec++;
    if ({o_valid, o_src[4], err} !== 3'b100) begin
      n_err++;
      $display("FAIL midburst_after: got v=%b grant=%b err=%b required 1 0 0", o_valid, o_src[4], err);
    end
    tick();
    o_ready = 1'b1;
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++;
      if (o_src[4] !== (c < 4)) begin
        n_err++;
        $display("FAIL midburst_restart[%0d]: got grant %b required %b", c, o_src[4], c < 4);
      end
      tick();
    end
    a_valid = '0;
  endtask

  task automatic test_bad_source();
    do_reset();
    t3_d_valid = 1'b1; t3_d_src = {2'b11, 4'h7}; t3_rd_ready = 3'b000;
    #1;
    n_vec++;
    if ({t3_d_ready_o, t3_rd_valid} !== 4'b1000) begin
      n_err++;
      $display("FAIL bad_sink: got rdy=%b v=%b required 1 000", t3_d_ready_o, t3_rd_valid);
    end
    tick();
    t3_d_valid = 1'b1; t3_d_src = {2'b10, 4'h1}; t3_rd_ready = 3'b100;
    #1;
    n_vec++;
    if ({t3_err, t3_rd_valid, t3_d_ready_o, t3_rd_src} !== {1'b1, 3'b100, 1'b1, 4'h1}) begin
      n_err++;
      $display("FAIL bad_err_set: got err=%b v=%b rdy=%b src=%h required 1 100 1 1", t3_err, t3_rd_valid,
               t3_d_ready_o, t3_rd_src);
    end
    tick(); t3_d_valid = 1'b0; tick(); tick();
    n_vec++;
    if (t3_err !== 1'b1) begin
      n_err++;
      $display("FAIL bad_err_sticky: got %b required 1", t3_err);
    end
    do_reset();
    n_vec++;
    if (t3_err !== 1'b0) begin
      n_err++;
      $display("FAIL bad_err_clear: got %b required 0", t3_err);
    end
  endtask

  task automatic test_random();
    int r_left[2];
    int g;
    bit exp_v, fired;
    do_reset();
    r_left[0] = 0; r_left[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!a_valid[i]) begin
          if (r_left[i] == 0) begin
            if ($urandom_range(0, 2) == 0) begin
              op_q[i] = 3'($urandom_range(0, 5)); sz_q[i] = 4'($urandom_range(0, 6));
              src_q[i] = 4'($urandom); adr_q[i] = $urandom; dat_q[i] = {$urandom, $urandom};
              r_left[i] = beats_of(op_q[i], sz_q[i]);
              a_valid[i] = 1'b1;
            end
          end else if ($urandom_range(0, 1) == 1) begin
            dat_q[i] = {$urandom, $urandom};
            a_valid[i] = 1'b1;
          end
        end
      end
      o_ready = ($urandom_range(0, 3) != 0);
      d_valid = 1'($urandom); d_src = 5'($urandom); rd_ready = 2'($urandom); d_data = {$urandom, $urandom};
      #1;
      g = m_grant();
      exp_v = (g >= 0) ? a_valid[g] : 1'b0;
      n_vec++;
      if ({o_valid, a_ready_o} !== {exp_v, (g >= 0 && o_ready) ? 2'(1 << g) : 2'b00}) begin
        n_err++;
        $display("FAIL rand_a_hs[%0d]: got v=%b rdy=%b required v=%b grant=%0d ready_in=%b", cyc, o_valid,
                 a_ready_o, exp_v, g, o_ready);
      end
      if (exp_v) begin
        n_vec++;
        if ({o_src, o_addr, o_data, o_op, o_size} !== {1'(g), src_q[g], adr_q[g], dat_q[g], op_q[g], sz_q[g]}) begin
          n_err++;
          $display("FAIL rand_a_bits[%0d]: got src=%h addr=%h data=%h op=%0d sz=%0d required src=%h addr=%h data=%h op=%0d sz=%0d",
                   cyc, o_src, o_addr, o_data, o_op, o_size, {1'(g), src_q[g]}, adr_q[g], dat_q[g], op_q[g], sz_q[g]);
        end
      end
      n_vec++;
      if ({rd_valid, d_ready_o, rd_src, rd_data} !==
          {d_valid ? 2'(1 << d_src[4]) : 2'b00, rd_ready[d_src[4]], d_src[3:0], d_data}) begin
        n_err++;
        $display("FAIL rand_d[%0d]: got v=%b rdy=%b src=%h required dv=%b src=%h rdy_in=%b", cyc, rd_valid,
                 d_ready_o, rd_src, d_valid, d_src, rd_ready);
      end
      fired = exp_v && o_ready;
      m_step(g, exp_v, o_ready);
      @(posedge clk); #1;
      if (fired) begin
        a_valid[g] = 1'b0;
        r_left[g]--;
      end
    end
    n_vec++;
    if (err !== 1'b0) begin
      n_err++;
      $display("FAIL rand_err: got %b required 0", err);
    end
    a_valid = '0; d_valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      op_q[i] = '0; sz_q[i] = '0; src_q[i] = '0; adr_q[i] = '0; dat_q[i] = '0;
    end
    m_reset();
    test_reset();
    test_single_get();
    test_alternate();
    test_burst_lock();
    test_stall_hold();
    test_d_route();
    test_reset_mid_burst();
    test_bad_source();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
